// File: rtl/zero_array_pkg.sv
// Shared types for the array shift engine: request opcodes and engine FSM states.
package zero_array_pkg;

  localparam int DefaultMemoryElementWidth = 12;

  typedef enum logic [2:0] {
    OP_WRITE      = 3'd0,
    OP_READ       = 3'd1,
    OP_SIZE       = 3'd2,
    OP_RESIZE     = 3'd3,
    OP_SHIFT_UP   = 3'd4,
    OP_SHIFT_DOWN = 3'd5
  } array_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP_MOVE,
    S_DOWN_MOVE,
    S_DONE
  } eng_state_t;

endpackage

// File: rtl/array_shift_engine_if.sv
// Request/response port bundle of the array shift engine.
interface array_shift_engine_if #(
  parameter int W       = 12,
  parameter int NArea   = 8,
  parameter int NArrays = 4,
  parameter int AW      = (NArrays > 1) ? $clog2(NArrays) : 1,
  parameter int IW      = $clog2(NArea + 1)
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_array;
  logic [IW-1:0] req_index;
  logic [W-1:0]  req_data;
  logic          resp_valid;
  logic [W-1:0]  resp_data;
  logic [IW-1:0] resp_size;
  logic          resp_error;

  modport master (
    output req_valid, req_op, req_array, req_index, req_data,
    input  req_ready, resp_valid, resp_data, resp_size, resp_error
  );

  modport slave (
    input  req_valid, req_op, req_array, req_index, req_data,
    output req_ready, resp_valid, resp_data, resp_size, resp_error
  );
endinterface

// File: rtl/array_store.sv
// Flat element store: one combinational read port, one synchronous write port, async clear.
module array_store #(
  parameter int W     = 12,
  parameter int Depth = 32,
  parameter int ADW   = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [ADW-1:0] raddr,
  output logic [W-1:0]   rdata,
  input  logic           we,
  input  logic [ADW-1:0] waddr,
  input  logic [W-1:0]   wdata
);
  logic [W-1:0] mem [Depth];

  assign rdata = mem[raddr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/array_shift_engine.sv
// Array shift engine: NArrays arrays of up to NArea elements in one flat store;
// insert/remove move one element per clock (one read + one write per cycle).
module array_shift_engine
  import zero_array_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NArea              = 8,
  parameter int NArrays            = 4
) (
  input logic           clock,
  input logic           reset,
  array_shift_engine_if.slave bus
);
  localparam int W     = MemoryElementWidth;
  localparam int AW    = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int IW    = $clog2(NArea + 1);
  localparam int Depth = NArrays * NArea;
  localparam int ADW   = (Depth > 1) ? $clog2(Depth) : 1;

  eng_state_t state_q, state_d;
  logic ready_q, err_q;
  logic [2:0] op_q;
  logic [AW-1:0] arr_q;
  logic [IW-1:0] idx_q, cur_q;
  logic [W-1:0] data_q, hold_q;
  logic [NArrays-1:0][IW-1:0] len_q;
  logic resp_valid_q, resp_error_q;
  logic [W-1:0] resp_data_q;
  logic [IW-1:0] resp_size_q;

  logic accept, arr_ok, op_ok, req_ok, arr_q_ok, we;
  logic [IW-1:0] cur_len, len_sel, len_new;
  logic [ADW-1:0] raddr, waddr;
  logic [W-1:0] rdata, wdata;

  function automatic logic [ADW-1:0] flat(input int a, input int i);
    return ADW'(a * NArea + i);
  endfunction

  array_store #(.W(W), .Depth(Depth), .ADW(ADW)) u_store (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_size  = resp_size_q;
  assign bus.resp_error = resp_error_q;

  // Request validation against the current length of the addressed array.
  always_comb begin
    accept  = bus.req_valid && ready_q;
    arr_ok  = int'(bus.req_array) < NArrays;
    cur_len = arr_ok ? len_q[bus.req_array] : '0;
    case (bus.req_op)
      OP_WRITE, OP_READ: op_ok = int'(bus.req_index) < NArea;
      OP_SIZE:           op_ok = 1'b1;
      OP_RESIZE:         op_ok = int'(bus.req_index) <= NArea;
      OP_SHIFT_UP:       op_ok = (bus.req_index <= cur_len) && (int'(cur_len) < NArea);
      OP_SHIFT_DOWN:     op_ok = bus.req_index < cur_len;
      default:           op_ok = 1'b0;
    endcase
    req_ok = arr_ok && op_ok;
  end

  assign arr_q_ok = int'(arr_q) < NArrays;
  assign len_sel  = arr_q_ok ? len_q[arr_q] : '0;

  always_comb begin
    len_new = len_sel;
    case (op_q)
      OP_WRITE:      if (idx_q >= len_sel) len_new = idx_q + IW'(1);
      OP_RESIZE:     len_new = idx_q;
      OP_SHIFT_UP:   len_new = len_sel + IW'(1);
      OP_SHIFT_DOWN: len_new = len_sel - IW'(1);
      default: ;
    endcase
  end

  // Idle reads the element a SHIFT_DOWN removes; move states read the neighbour being copied.
  always_comb begin
    case (state_q)
      S_UP_MOVE:   raddr = flat(int'(arr_q), int'(cur_q) - 1);
      S_DOWN_MOVE: raddr = flat(int'(arr_q), int'(cur_q) + 1);
      S_DONE:      raddr = flat(int'(arr_q), int'(idx_q));
      default:     raddr = flat(int'(bus.req_array), int'(bus.req_index));
    endcase
  end

  always_comb begin
    we    = 1'b0;
    waddr = flat(int'(arr_q), int'(cur_q));
    wdata = rdata;
    case (state_q)
      S_UP_MOVE, S_DOWN_MOVE: we = 1'b1;
      S_DONE: if (!err_q) begin
        case (op_q)
          OP_WRITE, OP_SHIFT_UP: begin
            we    = 1'b1;
            waddr = flat(int'(arr_q), int'(idx_q));
            wdata = data_q;
          end
          OP_SHIFT_DOWN: begin
            we    = 1'b1;
            waddr = flat(int'(arr_q), int'(len_sel) - 1);
            wdata = '0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (!req_ok)
          state_d = S_DONE;
        else if (bus.req_op == OP_SHIFT_UP && bus.req_index != cur_len)
          state_d = S_UP_MOVE;
        else if (bus.req_op == OP_SHIFT_DOWN && int'(bus.req_index) + 1 < int'(cur_len))
          state_d = S_DOWN_MOVE;
        else
          state_d = S_DONE;
      end
      S_UP_MOVE:   if (int'(cur_q) - 1 == int'(idx_q)) state_d = S_DONE;
      S_DOWN_MOVE: if (int'(cur_q) + 2 >= int'(len_sel)) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q <= '0; arr_q <= '0; idx_q <= '0; cur_q <= '0;
      data_q <= '0; hold_q <= '0; err_q <= 1'b0; len_q <= '0;
      resp_valid_q <= 1'b0; resp_error_q <= 1'b0;
      resp_data_q <= '0; resp_size_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      resp_size_q  <= '0;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q   <= bus.req_op;
          arr_q  <= bus.req_array;
          idx_q  <= bus.req_index;
          data_q <= bus.req_data;
          err_q  <= !req_ok;
          hold_q <= rdata;
          cur_q  <= (bus.req_op == OP_SHIFT_UP) ? cur_len : bus.req_index;
        end
        S_UP_MOVE:   cur_q <= cur_q - IW'(1);
        S_DOWN_MOVE: cur_q <= cur_q + IW'(1);
        S_DONE: begin
          resp_valid_q <= 1'b1;
          if (err_q) begin
            resp_error_q <= 1'b1;
            resp_size_q  <= len_sel;
          end else begin
            len_q[arr_q] <= len_new;
            resp_size_q  <= len_new;
            if (op_q == OP_READ)           resp_data_q <= rdata;
            else if (op_q == OP_SHIFT_DOWN) resp_data_q <= hold_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_array_shift_engine.sv
// Scoreboard bench for array_shift_engine: expectations queued on issue, checked on resp_valid.
module tb_array_shift_engine;
  import zero_array_pkg::*;

  localparam int W = 12, NAREA = 8, NARR = 4;
  localparam int AW = $clog2(NARR), IW = $clog2(NAREA + 1);

  typedef struct { string tag; int data; int size; int err; int lat; } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0;
  exp_t sb[$];

  array_shift_engine_if #(.W(W), .NArea(NAREA), .NArrays(NARR)) bus();

  array_shift_engine #(.MemoryElementWidth(W), .NArea(NAREA), .NArrays(NARR)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input int a, input int idx, input int d);
    bus.req_op    = op;
    bus.req_array = AW'(a);
    bus.req_index = IW'(idx);
    bus.req_data  = W'(d);
  endtask

  task automatic expect_resp(input string tag, input int data, input int size, input int err, input int lat);
    exp_t e;
    e.tag = tag; e.data = data; e.size = size; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 40) begin @(negedge clock); n++; end
    if (!bus.req_ready) chk({tag, ".ready_timeout"}, 32'(bus.req_ready), 1);
  endtask

  task automatic compare(input int n);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".valid"}, 32'(bus.resp_valid), 1);
    chk({e.tag, ".lat"},   n, e.lat);
    chk({e.tag, ".data"},  32'(bus.resp_data), e.data);
    chk({e.tag, ".size"},  32'(bus.resp_size), e.size);
    chk({e.tag, ".err"},   32'(bus.resp_error), e.err);
  endtask

  // Latency = posedges after the accepting edge until resp_valid is seen.
  task automatic collect();
    int n = 0;
    @(negedge clock);
    while (!bus.resp_valid && n < 40) begin @(negedge clock); n++; end
    compare(n);
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input int a, input int idx,
                       input int d, input int ed, input int es, input int ee, input int el);
    wait_ready(tag);
    drive(op, a, idx, d);
    bus.req_valid = 1'b1;
    expect_resp(tag, ed, es, ee, el);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    collect();
  endtask

  initial begin
    int n, busy, seen;
    bus.req_valid = 1'b0;
    drive(OP_WRITE, 0, 0, 0);

    // reset state
    repeat (3) @(negedge clock);
    chk("rst.ready", 32'(bus.req_ready), 0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 0);
    chk("rst.resp_data", 32'(bus.resp_data), 0);
    chk("rst.resp_size", 32'(bus.resp_size), 0);
    chk("rst.resp_error", 32'(bus.resp_error), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst.ready_rise", 32'(bus.req_ready), 1);

    // 1: insert in the middle of array 1
    for (int i = 0; i < 3; i++) issue($sformatf("t1.wr%0d", i), OP_WRITE, 1, i, i, 0, i + 1, 0, 1);
    issue("t1.su", OP_SHIFT_UP, 1, 2, 99, 0, 4, 0, 2);
    issue("t1.rd0", OP_READ, 1, 0, 0, 0, 4, 0, 1);
    issue("t1.rd1", OP_READ, 1, 1, 0, 1, 4, 0, 1);
    issue("t1.rd2", OP_READ, 1, 2, 0, 99, 4, 0, 1);
    issue("t1.rd3", OP_READ, 1, 3, 0, 2, 4, 0, 1);

    // 2: remove from the head
    issue("t2.sd", OP_SHIFT_DOWN, 1, 0, 0, 0, 3, 0, 4);
    issue("t2.rd0", OP_READ, 1, 0, 0, 1, 3, 0, 1);
    issue("t2.rd1", OP_READ, 1, 1, 0, 99, 3, 0, 1);
    issue("t2.rd2", OP_READ, 1, 2, 0, 2, 3, 0, 1);
    issue("t2.rd3", OP_READ, 1, 3, 0, 0, 3, 0, 1);

    // 3: error cases
    for (int i = 0; i < NAREA; i++) issue($sformatf("t3.fill%0d", i), OP_WRITE, 0, i, 10 + i, 0, i + 1, 0, 1);
    issue("t3.su_full", OP_SHIFT_UP, 0, 0, 5, 0, 8, 1, 1);
    issue("t3.rd0", OP_READ, 0, 0, 0, 10, 8, 0, 1);
    issue("t3.rd7", OP_READ, 0, 7, 0, 17, 8, 0, 1);
    issue("t3.su_pos", OP_SHIFT_UP, 1, 4, 5, 0, 3, 1, 1);
    issue("t3.sd_empty", OP_SHIFT_DOWN, 2, 0, 0, 0, 0, 1, 1);
    issue("t3.bad_op", 3'd6, 1, 0, 0, 0, 3, 1, 1);
    issue("t3.rd_oob", OP_READ, 1, 8, 0, 0, 3, 1, 1);

    // 4: requests held valid during an 8-cycle shift
    wait_ready("t4");
    drive(OP_SHIFT_DOWN, 0, 0, 0);
    bus.req_valid = 1'b1;
    expect_resp("t4.sd", 10, 7, 0, 8);
    @(posedge clock);
    #1 drive(OP_WRITE, 2, 0, 'h777);
    n = 0; busy = 0;
    @(negedge clock);
    while (!bus.resp_valid && n < 40) begin
      if (bus.req_ready) busy++;
      @(negedge clock); n++;
    end
    compare(n);
    chk("t4.busy_ready", busy, 0);
    chk("t4.ready_after_done", 32'(bus.req_ready), 1);
    expect_resp("t4.wr", 0, 1, 0, 1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    collect();
    issue("t4.rd0", OP_READ, 0, 0, 0, 11, 7, 0, 1);
    issue("t4.rd6", OP_READ, 0, 6, 0, 17, 7, 0, 1);
    issue("t4.rd7", OP_READ, 0, 7, 0, 0, 7, 0, 1);
    issue("t4.rd_a2", OP_READ, 2, 0, 0, 'h777, 1, 0, 1);

    // 5: reset in the middle of a shift
    wait_ready("t5");
    drive(OP_SHIFT_UP, 0, 0, 5);
    bus.req_valid = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clock); seen |= int'(bus.resp_valid); end
    reset = 1'b0;
    repeat (2) begin @(negedge clock); seen |= int'(bus.resp_valid); end
    reset = 1'b1;
    repeat (10) begin @(negedge clock); seen |= int'(bus.resp_valid); end
    chk("t5.no_resp", seen, 0);
    for (int a = 0; a < NARR; a++) issue($sformatf("t5.size%0d", a), OP_SIZE, a, 0, 0, 0, 0, 0, 1);
    issue("t5.rd_a0", OP_READ, 0, 0, 0, 0, 0, 0, 1);
    issue("t5.rd_a1", OP_READ, 1, 1, 0, 0, 0, 0, 1);

    // 6: resize
    issue("t6.rs5", OP_RESIZE, 3, 5, 0, 0, 5, 0, 1);
    issue("t6.rs9", OP_RESIZE, 3, 9, 0, 0, 5, 1, 1);
    issue("t6.wr7", OP_WRITE, 3, 7, 'h123, 0, 8, 0, 1);
    issue("t6.rd7", OP_READ, 3, 7, 0, 'h123, 8, 0, 1);
    issue("t6.rd2", OP_READ, 3, 2, 0, 0, 8, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
